// File: rtl/wb_write_arbiter.sv
// Purpose : merges the ALU/load result path and the buffered mul/div path onto the single register-file write port.
// Latency : the winning write appears on RegWrite/write_reg_addr/write_reg_data one edge after it is presented.
// Backpr. : ALU path is never stalled; long-latency path uses valid/ready (ready = FIFO not full), fe_stall throttles the ALU when the FIFO starves.
module wb_write_arbiter #(
   parameter int DATA_W       = 64,
   parameter int ADDR_W       = 5,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alu_wen,
   input  logic [ADDR_W-1:0]        alu_waddr,
   input  logic [DATA_W-1:0]        alu_wdata,
   input  logic                     ll_valid,
   output logic                     ll_ready,
   input  logic [ADDR_W-1:0]        ll_waddr,
   input  logic [DATA_W-1:0]        ll_wdata,
   output logic                     RegWrite,
   output logic [ADDR_W-1:0]        write_reg_addr,
   output logic [DATA_W-1:0]        write_reg_data,
   output logic                     fe_stall,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [SC_W-1:0]  LIMIT_C = SC_W'(STARVE_LIMIT);

   // FIFO storage: one address/data/live triple per slot
   logic [ADDR_W-1:0] q_addr [DEPTH];
   logic [DATA_W-1:0] q_data [DEPTH];
   logic [DEPTH-1:0]  q_live;

   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;

   logic [SC_W-1:0]   starve_cnt;
   logic [SC_W-1:0]   starve_nxt;

   // Per-cycle arbitration terms
   logic              alu_win;
   logic              fifo_ne;
   logic              pop;
   logic              xfer;
   logic              ll_nonzero;
   logic              bypass;
   logic              push;
   logic              push_live;
   logic              head_wr;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   assign fifo_count = count;

   // Ready depends on occupancy only, so a full FIFO popping this cycle still refuses.
   assign ll_ready   = (count < DEPTH_C);

   assign alu_win    = alu_wen && (alu_waddr != '0);
   assign fifo_ne    = (count != '0);
   assign pop        = !alu_win && fifo_ne;
   assign xfer       = ll_valid && ll_ready;
   assign ll_nonzero = (ll_waddr != '0);

   // Bypass only when nothing older is queued, so ordering is preserved.
   assign bypass     = !alu_win && !fifo_ne && ll_valid && ll_nonzero;

   // Accepted x0 results are consumed without being stored.
   assign push       = xfer && ll_nonzero && !bypass;

   // A same-cycle ALU write to the same register is younger, so the pushed entry is born dead.
   assign push_live  = !(alu_win && (ll_waddr == alu_waddr));

   assign head_addr  = q_addr[rd_ptr];
   assign head_data  = q_data[rd_ptr];
   assign head_wr    = q_live[rd_ptr] && (head_addr != '0);

   // FIFO pointers, occupancy and contents, including write-after-write kill of older entries
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         q_live <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_addr[i] <= '0;
            q_data[i] <= '0;
         end
      end else begin
         // Older queued results to the ALU's destination must never reach the register file.
         for (int i = 0; i < DEPTH; i++) begin
            if (alu_win && (q_addr[i] == alu_waddr)) begin
               q_live[i] <= 1'b0;
            end
         end
         if (push) begin
            q_addr[wr_ptr] <= ll_waddr;
            q_data[wr_ptr] <= ll_wdata;
            q_live[wr_ptr] <= push_live;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Register-file write port: ALU first, then FIFO head, then bypass; addr/data hold when idle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         RegWrite       <= 1'b0;
         write_reg_addr <= '0;
         write_reg_data <= '0;
      end else if (alu_win) begin
         RegWrite       <= 1'b1;
         write_reg_addr <= alu_waddr;
         write_reg_data <= alu_wdata;
      end else if (pop) begin
         RegWrite <= head_wr;
         if (head_wr) begin
            write_reg_addr <= head_addr;
            write_reg_data <= head_data;
         end
      end else if (bypass) begin
         RegWrite       <= 1'b1;
         write_reg_addr <= ll_waddr;
         write_reg_data <= ll_wdata;
      end else begin
         RegWrite <= 1'b0;
      end
   end

   // Starvation counter: counts consecutive ALU-preempted cycles while results are queued
   always_comb begin
      starve_nxt = starve_cnt;
      if (pop || !fifo_ne) begin
         starve_nxt = '0;
      end else if (alu_win && (starve_cnt != LIMIT_C)) begin
         starve_nxt = starve_cnt + 1'b1;
      end
   end

   // Starvation state and the registered front-end stall request
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
         fe_stall   <= 1'b0;
      end else begin
         starve_cnt <= starve_nxt;
         fe_stall   <= (starve_nxt >= LIMIT_C);
      end
   end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

   logic        clk;
   logic        reset;
   logic        alu_wen;
   logic [4:0]  alu_waddr;
   logic [63:0] alu_wdata;
   logic        ll_valid;
   logic        ll_ready;
   logic [4:0]  ll_waddr;
   logic [63:0] ll_wdata;
   logic        RegWrite;
   logic [4:0]  write_reg_addr;
   logic [63:0] write_reg_data;
   logic        fe_stall;
   logic [1:0]  fifo_count;

   int checks   = 0;
   int failures = 0;

   wb_write_arbiter #(
      .DATA_W(64), .ADDR_W(5), .DEPTH(2), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .alu_wen(alu_wen),
      .alu_waddr(alu_waddr),
      .alu_wdata(alu_wdata),
      .ll_valid(ll_valid),
      .ll_ready(ll_ready),
      .ll_waddr(ll_waddr),
      .ll_wdata(ll_wdata),
      .RegWrite(RegWrite),
      .write_reg_addr(write_reg_addr),
      .write_reg_data(write_reg_data),
      .fe_stall(fe_stall),
      .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Front end must keep alu_wen low while fe_stall is high
   always @(posedge clk) begin
      if (reset) begin
         assert (!(fe_stall && alu_wen))
            else $error("FAIL protocol: alu_wen=1 while fe_stall=1");
      end
   end

   typedef struct {
      logic        aw;
      logic [4:0]  aa;
      logic [63:0] ad;
      logic        lv;
      logic [4:0]  la;
      logic [63:0] ld;
      logic        rw;
      logic [4:0]  wa;
      logic [63:0] wd;
      logic        rdy;
      logic [1:0]  cnt;
      logic        stall;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic aw, input logic [4:0] aa, input logic [63:0] ad,
                               input logic lv, input logic [4:0] la, input logic [63:0] ld,
                               input logic rw, input logic [4:0] wa, input logic [63:0] wd,
                               input logic rdy, input logic [1:0] cnt, input logic stall);
      vec_t v;
      v.aw = aw; v.aa = aa; v.ad = ad;
      v.lv = lv; v.la = la; v.ld = ld;
      v.rw = rw; v.wa = wa; v.wd = wd;
      v.rdy = rdy; v.cnt = cnt; v.stall = stall;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic aw, input logic [4:0] aa, input logic [63:0] ad,
                        input logic lv, input logic [4:0] la, input logic [63:0] ld);
      alu_wen = aw; alu_waddr = aa; alu_wdata = ad;
      ll_valid = lv; ll_waddr = la; ll_wdata = ld;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      reset = 1'b0;

      // Directed vectors: inputs for one cycle, outputs expected after the following edge
      //                  aw aa     ad        lv la     ld        rw wa     wd        rdy cnt stall
      // ALU only
      vecs.push_back(mk(1, 5'd5,  64'h1234, 0, 5'd0,  64'h0,    1, 5'd5,  64'h1234, 1, 0, 0));
      vecs.push_back(mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    1, 0, 0));
      // bypass with empty FIFO
      vecs.push_back(mk(0, 5'd0,  64'h0,    1, 5'd7,  64'hAA,   1, 5'd7,  64'hAA,   1, 0, 0));
      vecs.push_back(mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    1, 0, 0));
      // ALU preempts, ll result buffered and written one cycle later
      vecs.push_back(mk(1, 5'd3,  64'h33,   1, 5'd7,  64'hAA,   1, 5'd3,  64'h33,   1, 1, 0));
      vecs.push_back(mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    1, 5'd7,  64'hAA,   1, 0, 0));
      vecs.push_back(mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    1, 0, 0));
      // fill to full, third offer held back
      vecs.push_back(mk(1, 5'd1,  64'h11,   1, 5'd10, 64'hA0,   1, 5'd1,  64'h11,   1, 1, 0));
      vecs.push_back(mk(1, 5'd2,  64'h22,   1, 5'd11, 64'hB1,   1, 5'd2,  64'h22,   0, 2, 0));
      vecs.push_back(mk(1, 5'd4,  64'h44,   1, 5'd12, 64'hC2,   1, 5'd4,  64'h44,   0, 2, 0));
      // drain in order; held third result accepted once ready returns
      vecs.push_back(mk(0, 5'd0,  64'h0,    1, 5'd12, 64'hC2,   1, 5'd10, 64'hA0,   1, 1, 0));
      vecs.push_back(mk(0, 5'd0,  64'h0,    1, 5'd12, 64'hC2,   1, 5'd11, 64'hB1,   1, 1, 0));
      vecs.push_back(mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    1, 5'd12, 64'hC2,   1, 0, 0));
      vecs.push_back(mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    1, 0, 0));
      // WAW kill of a queued entry
      vecs.push_back(mk(1, 5'd6,  64'h66,   1, 5'd9,  64'h1,    1, 5'd6,  64'h66,   1, 1, 0));
      vecs.push_back(mk(1, 5'd9,  64'h2,    0, 5'd0,  64'h0,    1, 5'd9,  64'h2,    1, 1, 0));
      vecs.push_back(mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    1, 0, 0));
      // same-cycle ALU and ll to x9: ll pushed dead
      vecs.push_back(mk(1, 5'd9,  64'h3,    1, 5'd9,  64'h99,   1, 5'd9,  64'h3,    1, 1, 0));
      vecs.push_back(mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    1, 0, 0));
      // x0 destinations never write
      vecs.push_back(mk(0, 5'd0,  64'h0,    1, 5'd0,  64'h55,   0, 5'd0,  64'h0,    1, 0, 0));
      vecs.push_back(mk(1, 5'd0,  64'h77,   0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    1, 0, 0));
      vecs.push_back(mk(1, 5'd0,  64'h77,   1, 5'd8,  64'h88,   1, 5'd8,  64'h88,   1, 0, 0));
      vecs.push_back(mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    1, 0, 0));
      // starvation: queued entry preempted four cycles
      vecs.push_back(mk(1, 5'd13, 64'hD0,   1, 5'd14, 64'hE0,   1, 5'd13, 64'hD0,   1, 1, 0));
      vecs.push_back(mk(1, 5'd15, 64'hF0,   0, 5'd0,  64'h0,    1, 5'd15, 64'hF0,   1, 1, 0));
      vecs.push_back(mk(1, 5'd16, 64'hF1,   0, 5'd0,  64'h0,    1, 5'd16, 64'hF1,   1, 1, 0));
      vecs.push_back(mk(1, 5'd17, 64'hF2,   0, 5'd0,  64'h0,    1, 5'd17, 64'hF2,   1, 1, 0));
      vecs.push_back(mk(1, 5'd18, 64'hF3,   0, 5'd0,  64'h0,    1, 5'd18, 64'hF3,   1, 1, 1));
      vecs.push_back(mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    1, 5'd14, 64'hE0,   1, 0, 0));
      vecs.push_back(mk(0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    0, 5'd0,  64'h0,    1, 0, 0));

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_regwrite", 64'(RegWrite), 64'd0);
      chk("reset_addr",     64'(write_reg_addr), 64'd0);
      chk("reset_data",     write_reg_data, 64'd0);
      chk("reset_ready",    64'(ll_ready), 64'd1);
      chk("reset_count",    64'(fifo_count), 64'd0);
      chk("reset_stall",    64'(fe_stall), 64'd0);
      reset = 1'b1;
      step();
      chk("idle_regwrite", 64'(RegWrite), 64'd0);

      // Table-driven main sequence
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].aw, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ld);
         step();
         chk($sformatf("v%0d_regwrite", i), 64'(RegWrite), 64'(vecs[i].rw));
         if (vecs[i].rw) begin
            chk($sformatf("v%0d_addr", i), 64'(write_reg_addr), 64'(vecs[i].wa));
            chk($sformatf("v%0d_data", i), write_reg_data, vecs[i].wd);
         end
         chk($sformatf("v%0d_ready", i), 64'(ll_ready), 64'(vecs[i].rdy));
         chk($sformatf("v%0d_count", i), 64'(fifo_count), 64'(vecs[i].cnt));
         chk($sformatf("v%0d_stall", i), 64'(fe_stall), 64'(vecs[i].stall));
      end

      // Reset mid-operation with two buffered results: nothing may be written afterwards
      drive(1, 5'd20, 64'h201, 1, 5'd21, 64'h211);
      step();
      chk("rst_fill1_count", 64'(fifo_count), 64'd1);
      drive(1, 5'd22, 64'h221, 1, 5'd23, 64'h231);
      step();
      chk("rst_fill2_count", 64'(fifo_count), 64'd2);
      chk("rst_fill2_regwrite", 64'(RegWrite), 64'd1);
      drive(0, 0, 0, 0, 0, 0);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_async_regwrite", 64'(RegWrite), 64'd0);
      chk("rst_async_addr",     64'(write_reg_addr), 64'd0);
      chk("rst_async_count",    64'(fifo_count), 64'd0);
      chk("rst_async_ready",    64'(ll_ready), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("post_rst%0d_regwrite", k), 64'(RegWrite), 64'd0);
         chk($sformatf("post_rst%0d_count", k), 64'(fifo_count), 64'd0);
         chk($sformatf("post_rst%0d_stall", k), 64'(fe_stall), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
